dl_scoreboard_32r: RTL
======================

DL_SCOREBOARD_32R -- requirements
Module: dl_scoreboard_32r

Interface
REQ-001 SHALL have parameter MAX_INFLIGHT, default 8, meaning the maximum number of outstanding register writes (legal range 1..31).
REQ-002 SHALL have parameter CNT_W, default $clog2(MAX_INFLIGHT+1), meaning the width of inflight_cnt.
REQ-003 clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 iss_val  input  1  an issuing instruction is presented.
REQ-006 iss_rdy  output  1  the scoreboard accepts the issue this cycle.
REQ-007 iss_wen  input  1  the issuing instruction writes a destination register.
REQ-008 iss_rd_oh  input  32  one-hot destination register, driven by the 5-to-32 decoder.
REQ-009 iss_rs1  input  5  source register 1 index.
REQ-010 iss_rs2  input  5  source register 2 index.
REQ-011 wb_val  input  1  a writeback completes this cycle.
REQ-012 wb_rd_oh  input  32  one-hot writeback register, driven by the 5-to-32 decoder.
REQ-013 flush  input  1  discard all pending writes.
REQ-014 busy  output  32  registered pending-write vector; bit 0 is constant 0.
REQ-015 inflight_cnt  output  CNT_W  registered count of set busy bits.
REQ-016 hazard  output  1  combinational RAW or WAW conflict indication.
REQ-017 err  output  1  sticky protocol-error flag.

Function
REQ-018 An issue SHALL fire when iss_val && iss_rdy.
REQ-019 The writeback clear vector SHALL be clr = wb_val && !flush ? (wb_rd_oh & busy) : 0.
REQ-020 Effective busy SHALL be beff = busy & ~clr, so a same-cycle writeback resolves hazards (writeback bypass).
REQ-021 hazard SHALL equal beff[iss_rs1] | beff[iss_rs2] | (iss_wen & |(beff & iss_rd_oh)); an index of 0 never causes a hazard.
REQ-022 iss_rdy SHALL equal !rst && !flush && !hazard && (inflight_cnt - popcount(clr) < MAX_INFLIGHT || !iss_wen || iss_rd_oh[0]).
REQ-023 The set vector SHALL be set = fire && iss_wen ? (iss_rd_oh & ~32'h1) : 0.
REQ-024 The next busy value SHALL be (busy & ~clr) | set, updated one cycle after the issue or writeback (latency 1).
REQ-025 inflight_cnt SHALL update to inflight_cnt + |set - popcount(clr), where popcount(clr) is 0 or 1 for legal input, and it SHALL always equal popcount(busy).
REQ-026 A simultaneous issue and writeback to the same register SHALL leave the bit set, because the clear applies first and the new issue owns the register.
REQ-027 A writeback to a non-busy register or to register 0 SHALL have no effect on busy or inflight_cnt and SHALL set err.
REQ-028 A non-one-hot wb_rd_oh with wb_val, or a non-one-hot iss_rd_oh on a fire with iss_wen, SHALL set err; busy then updates per REQ-024 with the raw vectors.
REQ-029 When flush is high, busy and inflight_cnt SHALL become 0 on the next edge, iss_rdy SHALL be 0, and writeback SHALL be ignored without setting err.
REQ-030 err SHALL remain set until rst.
REQ-031 When inflight_cnt reaches MAX_INFLIGHT, issues with a nonzero destination SHALL stall until a clear, and issues with no destination SHALL proceed if hazard-free.

Reset
REQ-032 While rst is high, iss_rdy SHALL be 0.
REQ-033 On a rising edge with rst high, busy SHALL become 0, inflight_cnt 0 and err 0; rst SHALL dominate flush, issue and writeback.
REQ-034 A reset asserted mid-operation SHALL discard all pending writes with no residual state.

Verification
REQ-035 Issue with wen=1 to rd=5 -> next cycle busy=32'h20 and cnt=1; then issue with rs1=5 -> hazard=1 and iss_rdy=0; wb to rd=5 in the same cycle -> hazard=0 and the issue fires.
REQ-036 Issue to rd=0 with wen=1 -> busy stays 0, cnt stays 0, no hazard on later rs1=0.
REQ-037 Fill 8 distinct registers (MAX_INFLIGHT=8) -> cnt=8 and a 9th issue with wen has iss_rdy=0; a no-wen issue has iss_rdy=1; one writeback -> the 9th issue fires in that same cycle and cnt remains 8.
REQ-038 Same-cycle issue rd=7 and wb rd=7 while 7 is busy -> busy[7] stays 1 and cnt unchanged.
REQ-039 wb to a non-busy register 3 -> err=1 and busy/cnt unchanged; flush with 4 pending -> busy=0, cnt=0 next cycle and iss_rdy=0 during flush.
REQ-040 rst asserted with 3 pending and err=1 -> next cycle busy=0, cnt=0, err=0.

Source files
------------

// File: rtl/dl_scoreboard_32r.sv
// Register scoreboard for a 32-entry register file: tracks outstanding writes,
// flags RAW/WAW hazards at issue, bypasses same-cycle writebacks, bounds the
// number of writes in flight, and records protocol errors in a sticky flag.
module dl_scoreboard_32r #(
  parameter int MAX_INFLIGHT = 8,
  parameter int CNT_W        = $clog2(MAX_INFLIGHT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iss_val,
  output logic             iss_rdy,
  input  logic             iss_wen,
  input  logic [31:0]      iss_rd_oh,
  input  logic [4:0]       iss_rs1,
  input  logic [4:0]       iss_rs2,
  input  logic             wb_val,
  input  logic [31:0]      wb_rd_oh,
  input  logic             flush,
  output logic [31:0]      busy,
  output logic [CNT_W-1:0] inflight_cnt,
  output logic             hazard,
  output logic             err
);

  // Number of set bits in a 32-bit vector.
  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int i = 0; i < 32; i++) n = n + 6'(v[i]);
    return n;
  endfunction

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [31:0] v);
    return (v != '0) && ((v & (v - 32'd1)) == '0);
  endfunction

  logic [31:0]      busy_q;
  logic [CNT_W-1:0] cnt_q;
  logic             err_q;

  logic [31:0] clr;
  logic [31:0] beff;
  logic [31:0] set;
  logic [31:0] busy_next;
  logic [5:0]  clr_pop;
  logic [5:0]  cnt_avail;
  logic        room;
  logic        fire;
  logic        err_event;

  // Writeback clear, effective busy, hazard, ready and the next busy vector.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a
    // variable unassigned, which would otherwise infer a latch.
    clr       = '0;
    set       = '0;
    err_event = 1'b0;

    if (wb_val && !flush) clr = wb_rd_oh & busy_q;
    beff = busy_q & ~clr;

    // Register 0 is never busy (bit 0 is held at 0), so index 0 cannot hazard.
    hazard = beff[iss_rs1] | beff[iss_rs2] | (iss_wen & (|(beff & iss_rd_oh)));

    // Capacity is judged after this cycle's writeback frees its entry.
    clr_pop   = popcount32(clr);
    cnt_avail = 6'(cnt_q) - clr_pop;
    room      = (cnt_avail < 6'(MAX_INFLIGHT)) || !iss_wen || iss_rd_oh[0];
    iss_rdy   = !rst && !flush && !hazard && room;
    fire      = iss_val && iss_rdy;

    // Clear applies before set, so an issue to the register being written
    // back in the same cycle keeps ownership of it.
    if (fire && iss_wen) set = iss_rd_oh & ~32'h1;
    busy_next = (busy_q & ~clr) | set;

    // Writebacks to idle registers or register 0, and multi-hot vectors.
    if (wb_val && !flush && (!is_onehot(wb_rd_oh) || ((wb_rd_oh & busy_q) == '0)))
      err_event = 1'b1;
    if (fire && iss_wen && !is_onehot(iss_rd_oh))
      err_event = 1'b1;
  end

  // State register: reset dominates flush, which dominates normal update.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      busy_q <= '0;
      cnt_q  <= '0;
      err_q  <= 1'b0;
    end else if (flush) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_next;
      // Counting the next vector directly keeps the count equal to the number
      // of busy bits even when illegal multi-hot vectors slip through.
      cnt_q  <= CNT_W'(popcount32(busy_next));
      if (err_event) err_q <= 1'b1;
    end
  end

  assign busy         = busy_q;
  assign inflight_cnt = cnt_q;
  assign err          = err_q;

endmodule
